// File: rtl/pipe_skid_reg64_pkg.sv
// Shared definitions for the 64-bit pipeline skid stage: state encoding
// (numerically equal to the number of held entries) and default width.
package pipe_skid_reg64_pkg;

  localparam int DATA_WIDTH = 64;

  // Encoding doubles as the occupancy count: 0, 1 or 2 words held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/pipe_skid_reg64_if.sv
// Upstream and downstream valid/ready/data bundle for the skid stage.
// The slave modport is the stage itself; the master modport is its environment.
interface pipe_skid_reg64_if
  import pipe_skid_reg64_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    input  out_ready,
    output out_data
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    output out_ready,
    input  out_data
  );

endinterface

// File: rtl/pipe_skid_reg64.sv
// Registered pipeline-stage receiver with a one-entry skid buffer.
// in_ready comes straight from a flop so no combinational ready path crosses
// the stage boundary; the skid entry absorbs the word that upstream may still
// present in the cycle after ready falls.
module pipe_skid_reg64
  import pipe_skid_reg64_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  pipe_skid_reg64_if.slave        bus,
  output logic [1:0]              occupancy
);

  state_t             state_reg;
  state_t             state_next;
  logic [WIDTH-1:0]   main_d_reg;
  logic [WIDTH-1:0]   skid_d_reg;
  logic               in_ready_reg;

  logic               accept;
  logic               issue;
  logic               load_main_in;
  logic               load_main_skid;
  logic               load_skid_in;

  // Main register is valid in BUSY and FULL; skid is valid only in FULL.
  assign bus.out_valid = (state_reg != ST_EMPTY);
  assign bus.out_data  = main_d_reg;
  assign bus.in_ready  = in_ready_reg;
  assign occupancy     = state_reg;

  assign accept = bus.in_valid & in_ready_reg;
  assign issue  = bus.out_valid & bus.out_ready;

  // Next-state and data-steering decisions; flush squashes everything.
  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_next   = ST_BUSY;
            load_main_in = 1'b1;
          end
        end
        ST_BUSY: begin
          if (accept && issue) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_next   = ST_FULL;
            load_skid_in = 1'b1;
          end else if (issue) begin
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the drain path matters.
          if (issue) begin
            state_next     = ST_BUSY;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  // State, data and registered ready; reset wins over flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_EMPTY;
      main_d_reg   <= '0;
      skid_d_reg   <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next != ST_FULL);
      if (load_main_in) begin
        main_d_reg <= bus.in_data;
      end else if (load_main_skid) begin
        main_d_reg <= skid_d_reg;
      end
      if (load_skid_in) begin
        skid_d_reg <= bus.in_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg64.sv
// Self-checking bench for pipe_skid_reg64: directed vector table for reset,
// streaming, backpressure, flush and reset corner cases, then a randomized
// run scored against a queue-based model of a two-entry FIFO stage.
module tb_pipe_skid_reg64;

  localparam int W = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [1:0] occupancy;

  pipe_skid_reg64_if #(.WIDTH(W)) bus ();

  pipe_skid_reg64 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;
    logic        exp_ov;
    logic        exp_ir;
    logic [1:0]  exp_occ;
    logic        chk_d;
    logic [63:0] exp_d;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic r, input logic f, input logic v,
                              input logic [63:0] d, input logic ordy,
                              input logic ov, input logic ir, input logic [1:0] occ,
                              input logic cd, input logic [63:0] ed);
    vec_t x;
    x.rst = r; x.flush = f; x.in_valid = v; x.in_data = d; x.out_ready = ordy;
    x.exp_ov = ov; x.exp_ir = ir; x.exp_occ = occ; x.chk_d = cd; x.exp_d = ed;
    vecs.push_back(x);
  endfunction

  // Random-phase state
  logic [63:0] q[$];
  logic        m_ready;
  logic        v, r, f, acc, iss, pre_ov;
  logic [63:0] d, pre_d, w;
  int          delivered;

  initial begin
    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;

    // Reset with data offered, then one idle cycle after reset falls
    add(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 0, 1, 64'h0);
    add(1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, 0, 1, 64'h0);
    add(0, 0, 0, 64'h0, 0, 0, 1, 0, 1, 64'h0);
    // Streaming at full rate
    add(0, 0, 1, 64'h1, 1, 1, 1, 1, 1, 64'h1);
    add(0, 0, 1, 64'h2, 1, 1, 1, 1, 1, 64'h2);
    add(0, 0, 1, 64'h3, 1, 1, 1, 1, 1, 64'h3);
    add(0, 0, 0, 64'h0, 1, 0, 1, 0, 0, 64'h0);
    // Backpressure: fill skid, hold, drain in order
    add(0, 0, 1, 64'hA, 0, 1, 1, 1, 1, 64'hA);
    add(0, 0, 1, 64'hB, 0, 1, 0, 2, 1, 64'hA);
    add(0, 0, 0, 64'h0, 0, 1, 0, 2, 1, 64'hA);
    add(0, 0, 0, 64'h0, 1, 1, 1, 1, 1, 64'hB);
    add(0, 0, 0, 64'h0, 1, 0, 1, 0, 0, 64'h0);
    // Flush while FULL with a same-cycle offered word
    add(0, 0, 1, 64'hA, 0, 1, 1, 1, 1, 64'hA);
    add(0, 0, 1, 64'hB, 0, 1, 0, 2, 1, 64'hA);
    add(0, 1, 1, 64'hC, 0, 0, 1, 0, 0, 64'h0);
    add(0, 0, 0, 64'h0, 1, 0, 1, 0, 0, 64'h0);
    // Flush in BUSY with same-cycle accept and issue: both dropped
    add(0, 0, 1, 64'hD, 0, 1, 1, 1, 1, 64'hD);
    add(0, 1, 1, 64'hE, 1, 0, 1, 0, 0, 64'h0);
    add(0, 0, 0, 64'h0, 1, 0, 1, 0, 0, 64'h0);
    // Drain from FULL while upstream keeps offering: offered word not taken
    add(0, 0, 1, 64'h5A, 0, 1, 1, 1, 1, 64'h5A);
    add(0, 0, 1, 64'h5B, 0, 1, 0, 2, 1, 64'h5A);
    add(0, 0, 1, 64'h77, 1, 1, 1, 1, 1, 64'h5B);
    add(0, 0, 0, 64'h0, 1, 0, 1, 0, 0, 64'h0);
    // Reset (with flush) while FULL clears data to zero
    add(0, 0, 1, 64'h11, 0, 1, 1, 1, 1, 64'h11);
    add(0, 0, 1, 64'h22, 0, 1, 0, 2, 1, 64'h11);
    add(1, 1, 1, 64'h33, 1, 0, 1, 0, 1, 64'h0);
    add(0, 0, 0, 64'h0, 1, 0, 1, 0, 1, 64'h0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; flush = vecs[i].flush;
      bus.in_valid = vecs[i].in_valid; bus.in_data = vecs[i].in_data;
      bus.out_ready = vecs[i].out_ready;
      tick();
      $display("[TB] vec %0d rst=%0b flush=%0b iv=%0b id=%h or=%0b -> ov=%0b ir=%0b occ=%0d od=%h",
               i, vecs[i].rst, vecs[i].flush, vecs[i].in_valid, vecs[i].in_data,
               vecs[i].out_ready, bus.out_valid, bus.in_ready, occupancy, bus.out_data);
      chk($sformatf("vec%0d_out_valid", i), {63'b0, bus.out_valid}, {63'b0, vecs[i].exp_ov});
      chk($sformatf("vec%0d_in_ready", i), {63'b0, bus.in_ready}, {63'b0, vecs[i].exp_ir});
      chk($sformatf("vec%0d_occupancy", i), {62'b0, occupancy}, {62'b0, vecs[i].exp_occ});
      if (vecs[i].chk_d) chk($sformatf("vec%0d_out_data", i), bus.out_data, vecs[i].exp_d);
    end

    // Randomized run against a two-entry FIFO model
    rst = 1'b0; flush = 1'b0;
    m_ready = 1'b1;
    delivered = 0;
    for (int c = 0; c < 10000; c++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 99) == 0);
      d = {$urandom(), $urandom()};
      bus.in_valid = v; bus.in_data = d; bus.out_ready = r; flush = f;
      pre_ov = bus.out_valid;
      pre_d  = bus.out_data;
      acc = v && m_ready;
      iss = (q.size() > 0) && r;
      tick();
      if (f) begin
        q.delete();
      end else begin
        if (iss) begin
          w = q.pop_front();
          delivered++;
          chk("rnd_order", pre_d, w);
          $display("[TB] rnd cycle %0d delivered #%0d data=%h", c, delivered, pre_d);
        end
        if (acc) q.push_back(d);
      end
      m_ready = (q.size() < 2);
      chk("rnd_out_valid", {63'b0, bus.out_valid}, {63'b0, (q.size() > 0)});
      chk("rnd_occupancy", {62'b0, occupancy}, 64'(q.size()));
      chk("rnd_in_ready", {63'b0, bus.in_ready}, {63'b0, m_ready});
      if (q.size() > 0) chk("rnd_out_data", bus.out_data, q[0]);
      if (pre_ov && !r && !f) chk("rnd_stable", bus.out_data, pre_d);
    end

    bus.in_valid = 1'b0; bus.out_ready = 1'b1; flush = 1'b0;
    tick();
    tick();
    chk("final_drained", {62'b0, occupancy}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
